// File: rtl/nibble_add_pkg.sv
// Purpose: shared types and constants for the nibble-serial adder sequencer.
// Contents: slice width, FSM state encoding, requester ID type.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/nibble_adder.sv
// Purpose: 4-bit ripple-carry adder slice built from full adders.
// Ports:
//   a, b  in  4  operand nibbles
//   cin   in  1  carry in
//   s     out 4  sum nibble
//   cout  out 1  carry out
module nibble_adder
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Purpose: time-shares one 4-bit adder slice between two requesters,
// adding W-bit operands one nibble per cycle (LS nibble first) and
// returning a W+1-bit sum tagged with the issuing requester's ID.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0_valid / req0_ready  requester 0 handshake (ready is combinational)
//   req0_a, req0_b           requester 0 operands (W bits)
//   req1_*                   same for requester 1
//   rsp_valid / rsp_ready    result handshake
//   rsp_sum                  W+1-bit result, bit W is the final carry
//   rsp_id                   requester that issued the operation
//
// state | meaning
// IDLE  | arbitrate round-robin, accept one request
// RUN   | one nibble per cycle through the shared slice
// DONE  | result held on rsp_* until rsp_ready
module nibble_add_sequencer
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   req0_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   req0_b,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   req1_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   req1_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [NIBBLE_W*NIBBLES:0]     rsp_sum,
    output logic                          rsp_id
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W:0]       r_res;
    req_id_t          r_id;
    req_id_t          r_last;
    logic             r_rsp_valid;

    logic                w_any_valid;
    req_id_t             w_gnt_id;
    logic                w_accept;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum_nib;
    logic                w_cout;

    // On a tie the requester that did not win last time is granted;
    // otherwise whichever one is valid (req1_valid alone selects ID 1).
    assign w_any_valid = req0_valid | req1_valid;
    assign w_gnt_id    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_accept    = (r_state == IDLE) & w_any_valid;
    assign req0_ready  = w_accept & (w_gnt_id == 1'b0);
    assign req1_ready  = w_accept & (w_gnt_id == 1'b1);

    assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .s    (w_sum_nib),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_a     <= w_gnt_id ? req1_a : req0_a;
                        r_b     <= w_gnt_id ? req1_b : req0_b;
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res[r_idx*NIBBLE_W +: NIBBLE_W] <= w_sum_nib;
                    r_carry <= w_cout;
                    if (r_idx == IDX_LAST) begin
                        r_res[W]    <= w_cout;
                        r_idx       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_res;
    assign rsp_id    = r_id;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
module tb_nibble_add_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int LAT     = NIBBLES + 1;
    localparam int TIMEOUT = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready;
    logic [W:0]   rsp_sum;
    logic         rsp_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id)
    );

    // Reference: exact unsigned sum in W+1 bits.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int sel, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (sel == 0) begin
            req0_valid = v; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
        end
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Waits (bounded) until requester sel is granted; the next tick is the accept edge.
    task automatic wait_grant(input int sel);
        int n;
        #1;
        n = 0;
        while (((sel == 0) ? req0_ready : req1_ready) !== 1'b1 && n < TIMEOUT) begin
            tick();
            n++;
        end
        if (n >= TIMEOUT) begin
            n_errors++;
            $display("FAIL grant_timeout: requester %0d not granted within %0d cycles", sel, TIMEOUT);
        end
    endtask

    // Counts cycles after the accept edge (first cycle after it is 1) until rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        if (lat >= TIMEOUT) begin
            n_errors++;
            $display("FAIL rsp_timeout: rsp_valid not seen within %0d cycles", TIMEOUT);
        end
    endtask

    task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W:0] sum, output logic id);
        set_req(sel, 1'b1, a, b);
        wait_grant(sel);
        tick();
        set_req(sel, 1'b0, a, b);
        wait_rsp(lat);
        sum = rsp_sum;
        id  = rsp_id;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_sum !== '0) begin n_errors++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
        n_checks++; if (rsp_id !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready_idle: got %b%b want 00", req0_ready, req1_ready); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL reset_first_tie: got %b%b want 10", req0_ready, req1_ready); end
        req0_valid = 1'b0; #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_errors++; $display("FAIL reset_only_req1: got %b%b want 01", req0_ready, req1_ready); end
        req1_valid = 1'b0; #1;
    endtask

    task automatic test_single();
        int lat; logic [W:0] sum; logic id;
        run_op(0, 16'h1234, 16'h4321, lat, sum, id);
        n_checks++; if (sum !== 17'h05555) begin n_errors++; $display("FAIL single_sum: got %h want 05555", sum); end
        n_checks++; if (id !== 1'b0) begin n_errors++; $display("FAIL single_id: got %b want 0", id); end
        n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_carry();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb_ [3];
        logic [W:0]   te [3];
        int           ts [3];
        int lat; logic [W:0] sum; logic id;
        ta = '{16'hFFFF, 16'hFFFF, 16'h0000};
        tb_ = '{16'h0001, 16'hFFFF, 16'h0000};
        te = '{17'h10000, 17'h1FFFE, 17'h00000};
        ts = '{0, 0, 1};
        for (int i = 0; i < 3; i++) begin
            run_op(ts[i], ta[i], tb_[i], lat, sum, id);
            n_checks++; if (sum !== te[i]) begin n_errors++; $display("FAIL carry_sum[%0d]: got %h want %h", i, sum, te[i]); end
            n_checks++; if (id !== ts[i][0]) begin n_errors++; $display("FAIL carry_id[%0d]: got %b want %0d", i, id, ts[i]); end
        end
    endtask

    task automatic test_random();
        int lat; logic [W:0] sum; logic id;
        int sel; logic [W-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 1));
            a = rnd();
            b = rnd();
            run_op(sel, a, b, lat, sum, id);
            n_checks++; if (sum !== ref_sum(a, b)) begin n_errors++; $display("FAIL random_sum[%0d]: %h+%h got %h want %h", i, a, b, sum, ref_sum(a, b)); end
            n_checks++; if (id !== sel[0]) begin n_errors++; $display("FAIL random_id[%0d]: got %b want %0d", i, id, sel); end
            n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] a0, b0, a1, b1;
        logic [W:0]   exp_sum_q [$];
        logic         exp_id_q  [$];
        logic [W:0]   es;
        logic         eid, exp_gnt, gid;
        int           last_acc, n_acc;
        bit           acc;
        apply_reset();
        a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
        set_req(0, 1'b1, a0, b0);
        set_req(1, 1'b1, a1, b1);
        #1;
        exp_gnt = 1'b0; last_acc = -1; n_acc = 0; gid = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = (req0_ready | req1_ready);
            if (acc) begin
                gid = req1_ready;
                n_acc++;
                n_checks++; if (req0_ready & req1_ready) begin n_errors++; $display("FAIL contention_both_ready: cycle %0d", cyc); end
                n_checks++; if (gid !== exp_gnt) begin n_errors++; $display("FAIL contention_grant: cycle %0d got %b want %b", cyc, gid, exp_gnt); end
                if (last_acc >= 0) begin
                    n_checks++; if (cyc - last_acc != NIBBLES + 2) begin n_errors++; $display("FAIL contention_spacing: got %0d want %0d", cyc - last_acc, NIBBLES + 2); end
                end
                last_acc = cyc;
                exp_gnt  = ~exp_gnt;
                exp_sum_q.push_back(gid ? ref_sum(a1, b1) : ref_sum(a0, b0));
                exp_id_q.push_back(gid);
            end
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_sum_q.size() == 0) begin
                    n_errors++; $display("FAIL contention_extra_rsp: cycle %0d got %h want none", cyc, rsp_sum);
                end else begin
                    es = exp_sum_q.pop_front();
                    eid = exp_id_q.pop_front();
                    if (rsp_sum !== es || rsp_id !== eid) begin
                        n_errors++; $display("FAIL contention_rsp: got %h id %b want %h id %b", rsp_sum, rsp_id, es, eid);
                    end
                end
            end
            tick();
            if (acc) begin
                if (gid) begin a1 = rnd(); b1 = rnd(); set_req(1, 1'b1, a1, b1); end
                else     begin a0 = rnd(); b0 = rnd(); set_req(0, 1'b1, a0, b0); end
                #1;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 20 && exp_sum_q.size() > 0; i++) begin
            if (rsp_valid === 1'b1) begin
                es = exp_sum_q.pop_front();
                eid = exp_id_q.pop_front();
                n_checks++;
                if (rsp_sum !== es || rsp_id !== eid) begin
                    n_errors++; $display("FAIL contention_drain_rsp: got %h id %b want %h id %b", rsp_sum, rsp_id, es, eid);
                end
            end
            tick();
        end
        n_checks++; if (exp_sum_q.size() != 0) begin n_errors++; $display("FAIL contention_missing_rsp: got %0d outstanding want 0", exp_sum_q.size()); end
        n_checks++; if (n_acc != 7) begin n_errors++; $display("FAIL contention_accepts: got %0d want 7", n_acc); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a0, b0, a1, b1;
        logic [W:0]   hold;
        int lat;
        a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, a0, b0);
        wait_grant(0);
        tick();
        set_req(0, 1'b0, a0, b0);
        wait_rsp(lat);
        n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (rsp_sum !== ref_sum(a0, b0)) begin n_errors++; $display("FAIL bp_sum: got %h want %h", rsp_sum, ref_sum(a0, b0)); end
        hold = ref_sum(a0, b0);
        set_req(0, 1'b1, rnd(), rnd());
        set_req(1, 1'b1, a1, b1);
        #1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== hold || {req0_ready, req1_ready} !== 2'b00) begin
                n_errors++; $display("FAIL bp_hold[%0d]: got valid %b sum %h ready %b%b want 1 %h 00", i, rsp_valid, rsp_sum, req0_ready, req1_ready, hold);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tick();
        // Previous winner was requester 0, so the tie goes to requester 1.
        n_checks++; if ({req0_ready, req1_ready} !== 2'b01 || rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_release: got ready %b%b valid %b want 01 0", req0_ready, req1_ready, rsp_valid);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat);
        n_checks++; if (rsp_sum !== ref_sum(a1, b1) || rsp_id !== 1'b1) begin
            n_errors++; $display("FAIL bp_next_rsp: got %h id %b want %h id 1", rsp_sum, rsp_id, ref_sum(a1, b1));
        end
        n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL bp_next_latency: got %0d want %0d", lat, LAT); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a, b;
        int lat; logic [W:0] sum; logic id;
        a = rnd() | 16'h8888; b = rnd() | 16'h1111;
        set_req(0, 1'b1, a, b);
        wait_grant(0);
        tick();
        set_req(0, 1'b0, a, b);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
            n_errors++; $display("FAIL rst_run_outputs: got valid %b sum %h id %b ready %b%b want all 0", rsp_valid, rsp_sum, rsp_id, req0_ready, req1_ready);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_run_no_rsp[%0d]: got %b want 0", i, rsp_valid); end
            tick();
        end
        a = rnd(); b = rnd();
        run_op(1, a, b, lat, sum, id);
        n_checks++; if (sum !== ref_sum(a, b) || id !== 1'b1) begin
            n_errors++; $display("FAIL rst_run_after: got %h id %b want %h id 1", sum, id, ref_sum(a, b));
        end
    endtask

    task automatic test_operand_change();
        logic [W-1:0] a, b;
        int lat;
        a = rnd(); b = rnd();
        set_req(0, 1'b1, a, b);
        wait_grant(0);
        tick();
        req0_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < TIMEOUT) begin
            req0_a = ~a ^ rnd();
            req0_b = rnd();
            tick();
            lat++;
        end
        n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL opchg_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (rsp_sum !== ref_sum(a, b) || rsp_id !== 1'b0) begin
            n_errors++; $display("FAIL opchg_sum: got %h id %b want %h id 0", rsp_sum, rsp_id, ref_sum(a, b));
        end
        tick();
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_carry();
        test_random();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        test_operand_change();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
